// File: rtl/conv3x3_window_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_window_mac
//  Purpose  : Programmable signed 3x3 convolution over a streamed pixel
//             window. The result is arithmetically shifted right, clamped to
//             an unsigned pixel, and emitted only for windows that lie fully
//             inside the image.
//  Ports    : CLK, CLR       - clock, synchronous active-high reset
//             R00..R22       - window taps (row 0 oldest, column 2 newest)
//             Valid_IN       - window strobe
//             Coef_WE/Addr/Data - coefficient bank write port (0..8 row-major)
//             Out, Valid_OUT - filtered pixel and its qualifier (latency 3)
//             Frame_Done     - pulse with the last interior output of a frame
//  Revision : 1.0  initial release
// ============================================================================
module conv3x3_window_mac #(
  parameter int IMG_Width  = 5,
  parameter int IMG_Height = 5,
  parameter int Datawidth  = 8,
  parameter int CoefWidth  = 8,
  parameter int Shift      = 4
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [Datawidth-1:0] R00,
  input  logic [Datawidth-1:0] R01,
  input  logic [Datawidth-1:0] R02,
  input  logic [Datawidth-1:0] R10,
  input  logic [Datawidth-1:0] R11,
  input  logic [Datawidth-1:0] R12,
  input  logic [Datawidth-1:0] R20,
  input  logic [Datawidth-1:0] R21,
  input  logic [Datawidth-1:0] R22,
  input  logic                 Valid_IN,
  input  logic                 Coef_WE,
  input  logic [3:0]           Coef_Addr,
  input  logic [CoefWidth-1:0] Coef_Data,
  output logic [Datawidth-1:0] Out,
  output logic                 Valid_OUT,
  output logic                 Frame_Done
);

  localparam int PROD_W = Datawidth + 1 + CoefWidth;
  localparam int ROW_W  = PROD_W + 2;
  localparam int SUM_W  = Datawidth + CoefWidth + 5;
  localparam int COL_W  = $clog2(IMG_Width);
  localparam int ROW_W_CNT = $clog2(IMG_Height);
  localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_Width - 1);
  localparam logic [ROW_W_CNT-1:0] ROW_LAST = ROW_W_CNT'(IMG_Height - 1);
  localparam logic [CoefWidth-1:0] K_IDENT  = CoefWidth'(1 << Shift);

  // Coefficient bank, row-major K00..K22.
  logic signed [CoefWidth-1:0] r_coef [9];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int k = 0; k < 9; k++) begin
        r_coef[k] <= (k == 4) ? K_IDENT : '0;
      end
    end else if (Coef_WE && (Coef_Addr <= 4'd8)) begin
      r_coef[Coef_Addr] <= Coef_Data;
    end
  end

  // Raster position of R22 for the window currently on the inputs.
  logic [COL_W-1:0]     r_col;
  logic [ROW_W_CNT-1:0] r_row;
  logic                 w_interior;
  logic                 w_last;

  assign w_interior = (r_row >= ROW_W_CNT'(2)) && (r_col >= COL_W'(2));
  assign w_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_col <= '0;
      r_row <= '0;
    end else if (Valid_IN) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // S1: products. Taps are zero-extended so they stay non-negative; the
  // product uses the coefficient register as it stands before this edge,
  // so a same-cycle write only affects later windows.
  logic [Datawidth-1:0]     w_tap  [9];
  logic signed [PROD_W-1:0] w_prod [9];
  logic signed [PROD_W-1:0] r_prod [9];

  assign w_tap[0] = R00;
  assign w_tap[1] = R01;
  assign w_tap[2] = R02;
  assign w_tap[3] = R10;
  assign w_tap[4] = R11;
  assign w_tap[5] = R12;
  assign w_tap[6] = R20;
  assign w_tap[7] = R21;
  assign w_tap[8] = R22;

  genvar gk;
  generate
    for (gk = 0; gk < 9; gk++) begin : g_prod
      assign w_prod[gk] = $signed({{CoefWidth{1'b0}}, w_tap[gk]}) *
                          $signed({{(Datawidth+1){r_coef[gk][CoefWidth-1]}}, r_coef[gk]});
    end
  endgenerate

  // S2: per-row partial sums.
  logic signed [ROW_W-1:0] w_row_sum [3];
  logic signed [ROW_W-1:0] r_row_sum [3];

  generate
    for (gk = 0; gk < 3; gk++) begin : g_rows
      assign w_row_sum[gk] =
          $signed({{2{r_prod[3*gk][PROD_W-1]}},   r_prod[3*gk]})   +
          $signed({{2{r_prod[3*gk+1][PROD_W-1]}}, r_prod[3*gk+1]}) +
          $signed({{2{r_prod[3*gk+2][PROD_W-1]}}, r_prod[3*gk+2]});
    end
  endgenerate

  // S3: total sum; the output register applies shift and clamp.
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_shifted;
  logic [Datawidth-1:0]    w_clamped;

  assign w_sum = $signed({{2{r_row_sum[0][ROW_W-1]}}, r_row_sum[0]}) +
                 $signed({{2{r_row_sum[1][ROW_W-1]}}, r_row_sum[1]}) +
                 $signed({{2{r_row_sum[2][ROW_W-1]}}, r_row_sum[2]});

  assign w_shifted = r_sum >>> Shift;

  always_comb begin
    w_clamped = w_shifted[Datawidth-1:0];
    if (w_shifted[SUM_W-1]) begin
      w_clamped = '0;
    end else if (|w_shifted[SUM_W-2:Datawidth]) begin
      w_clamped = '1;
    end
  end

  // Datapath registers carry no reset; only their valid bits matter.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 9; k++) begin
      r_prod[k] <= w_prod[k];
    end
    for (int k = 0; k < 3; k++) begin
      r_row_sum[k] <= w_row_sum[k];
    end
    r_sum <= w_sum;
  end

  // Valid / last-window tags travel alongside the data.
  logic r_v1, r_v2, r_v3;
  logic r_l1, r_l2, r_l3;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_l1       <= 1'b0;
      r_l2       <= 1'b0;
      r_l3       <= 1'b0;
      Valid_OUT  <= 1'b0;
      Frame_Done <= 1'b0;
      Out        <= '0;
    end else begin
      r_v1       <= Valid_IN & w_interior;
      r_l1       <= Valid_IN & w_interior & w_last;
      r_v2       <= r_v1;
      r_l2       <= r_l1;
      r_v3       <= r_v2;
      r_l3       <= r_l2;
      Valid_OUT  <= r_v3;
      Frame_Done <= r_v3 & r_l3;
      if (r_v3) begin
        Out <= w_clamped;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_window_mac
//  Purpose  : Self-checking bench for conv3x3_window_mac. Windows are driven
//             with random or fixed taps; a behavioural model tracks raster
//             position and coefficients and predicts each output value, its
//             arrival cycle and the frame-done flag.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv3x3_window_mac;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int SH = 4;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] tap [9];
  logic       Valid_IN;
  logic       Coef_WE;
  logic [3:0] Coef_Addr;
  logic [7:0] Coef_Data;
  logic [7:0] Out;
  logic       Valid_OUT;
  logic       Frame_Done;

  conv3x3_window_mac #(
    .IMG_Width(W), .IMG_Height(H), .Datawidth(8), .CoefWidth(8), .Shift(SH)
  ) dut (
    .CLK(CLK), .CLR(CLR),
    .R00(tap[0]), .R01(tap[1]), .R02(tap[2]),
    .R10(tap[3]), .R11(tap[4]), .R12(tap[5]),
    .R20(tap[6]), .R21(tap[7]), .R22(tap[8]),
    .Valid_IN(Valid_IN), .Coef_WE(Coef_WE), .Coef_Addr(Coef_Addr),
    .Coef_Data(Coef_Data), .Out(Out), .Valid_OUT(Valid_OUT),
    .Frame_Done(Frame_Done)
  );

  always #5 CLK = ~CLK;

  // Edge counter: at a falling edge, cyc equals the index of the last rising edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int c;
    int v;
    bit fd;
  } obs_t;

  obs_t obs_q[$];
  obs_t exp_q[$];
  int   stray_fd = 0;

  always @(negedge CLK) begin
    if (Valid_OUT === 1'b1) obs_q.push_back('{cyc, int'(Out), Frame_Done});
    else if (Frame_Done !== 1'b0) stray_fd++;
  end

  // Reference model state
  int kc [9];
  int win [9];
  int prow, pcol;
  int total = 0;
  int bad   = 0;

  function automatic int model_val();
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += win[k] * kc[k];
    s = s >>> SH;
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) kc[k] = 0;
    kc[4] = 1 << SH;
    prow = 0;
    pcol = 0;
  endtask

  // Drive one window; optional coefficient write in the same cycle.
  task automatic send(input bit we = 1'b0, input int addr = 0, input int data = 0);
    @(negedge CLK);
    for (int k = 0; k < 9; k++) tap[k] = 8'(win[k]);
    Valid_IN  = 1'b1;
    Coef_WE   = we;
    Coef_Addr = 4'(addr);
    Coef_Data = 8'(data);
    if (prow >= 2 && pcol >= 2)
      exp_q.push_back('{cyc + 4, model_val(), (prow == H-1 && pcol == W-1)});
    if (pcol == W-1) begin
      pcol = 0;
      prow = (prow == H-1) ? 0 : prow + 1;
    end else begin
      pcol = pcol + 1;
    end
    if (we && addr <= 8) kc[addr] = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      Valid_IN = 1'b0;
      Coef_WE  = 1'b0;
    end
  endtask

  task automatic wcoef(input int addr, input int data);
    @(negedge CLK);
    Valid_IN  = 1'b0;
    Coef_WE   = 1'b1;
    Coef_Addr = 4'(addr);
    Coef_Data = 8'(data);
    if (addr <= 8) kc[addr] = data;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    CLR      = 1'b1;
    Valid_IN = 1'b0;
    Coef_WE  = 1'b0;
    // Anything due at or after the reset edge is discarded.
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].c >= cyc + 1) exp_q.delete(i);
    model_reset();
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic rand_taps();
    for (int k = 0; k < 9; k++) win[k] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_taps(input int v);
    for (int k = 0; k < 9; k++) win[k] = v;
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    CLR = 1'b1; Valid_IN = 1'b0; Coef_WE = 1'b0; Coef_Addr = '0; Coef_Data = '0;
    for (int k = 0; k < 9; k++) tap[k] = 8'hFF;
    model_reset();
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    total++; if (Out !== 8'd0)       begin bad++; $display("FAIL reset Out: got %0d want 0", Out); end
    total++; if (Valid_OUT !== 1'b0) begin bad++; $display("FAIL reset Valid_OUT: got %b want 0", Valid_OUT); end
    total++; if (Frame_Done !== 1'b0) begin bad++; $display("FAIL reset Frame_Done: got %b want 0", Frame_Done); end
  endtask

  task automatic test_identity();
    int nfd;
    clear_q();
    fill_taps(37);
    repeat (25) send();
    idle(6);
    nfd = 0;
    total++;
    if (obs_q.size() != 9) begin bad++; $display("FAIL identity count: got %0d want 9", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].v != 37 || obs_q[i].c != exp_q[i].c || obs_q[i].fd != (i == 8)) begin
        bad++;
        $display("FAIL identity out[%0d]: got val=%0d cyc=%0d fd=%0b want val=37 cyc=%0d fd=%0b",
                 i, obs_q[i].v, obs_q[i].c, obs_q[i].fd, exp_q[i].c, (i == 8));
      end
      if (obs_q[i].fd) nfd++;
    end
    total++;
    if (nfd != 1) begin bad++; $display("FAIL identity frame_done count: got %0d want 1", nfd); end
  endtask

  task automatic test_box();
    clear_q();
    for (int k = 0; k < 9; k++) wcoef(k, 1);
    fill_taps(100);
    repeat (25) send();
    idle(6);
    total++;
    if (obs_q.size() != 9) begin bad++; $display("FAIL box count: got %0d want 9", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].v != 56) begin bad++; $display("FAIL box out[%0d]: got %0d want 56", i, obs_q[i].v); end
    end
  endtask

  task automatic test_sobel();
    int want [3];
    int sob [9];
    want[0] = 0; want[1] = 50; want[2] = 255;
    sob = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    clear_q();
    for (int k = 0; k < 9; k++) wcoef(k, sob[k]);
    for (int k = 0; k < 9; k++) win[k] = (k % 3 == 0) ? 200 : 0;
    repeat (25) send();
    for (int k = 0; k < 9; k++) win[k] = (k % 3 == 2) ? 200 : 0;
    repeat (25) send();
    for (int k = 0; k < 9; k++) wcoef(k, (k == 4) ? 32 : 0);
    fill_taps(200);
    repeat (25) send();
    idle(6);
    total++;
    if (obs_q.size() != 27) begin bad++; $display("FAIL sobel count: got %0d want 27", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 27; i++) begin
      total++;
      if (obs_q[i].v != want[i / 9]) begin
        bad++; $display("FAIL sobel out[%0d]: got %0d want %0d", i, obs_q[i].v, want[i / 9]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q();
    for (int k = 0; k < 9; k++) wcoef(k, int'($urandom_range(0, 40)) - 12);
    for (int n = 0; n < 25; n++) begin
      rand_taps();
      send();
      idle(int'($urandom_range(0, 3)));
    end
    idle(6);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL gaps count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].v != exp_q[i].v || obs_q[i].c != exp_q[i].c || obs_q[i].fd != exp_q[i].fd) begin
        bad++;
        $display("FAIL gaps out[%0d]: got val=%0d cyc=%0d fd=%0b want val=%0d cyc=%0d fd=%0b",
                 i, obs_q[i].v, obs_q[i].c, obs_q[i].fd, exp_q[i].v, exp_q[i].c, exp_q[i].fd);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    wcoef(0, 7);
    wcoef(8, -5);
    for (int n = 0; n < 15; n++) begin rand_taps(); send(); end
    pulse_reset();
    idle(4);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL reset_mid in-flight: got %0d outputs want 0", obs_q.size()); end
    clear_q();
    for (int n = 0; n < 25; n++) begin rand_taps(); send(); end
    idle(6);
    total++;
    if (obs_q.size() != 9) begin bad++; $display("FAIL reset_mid count: got %0d want 9", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].v != exp_q[i].v || obs_q[i].c != exp_q[i].c || obs_q[i].fd != exp_q[i].fd) begin
        bad++;
        $display("FAIL reset_mid out[%0d]: got val=%0d cyc=%0d fd=%0b want val=%0d cyc=%0d fd=%0b",
                 i, obs_q[i].v, obs_q[i].c, obs_q[i].fd, exp_q[i].v, exp_q[i].c, exp_q[i].fd);
      end
    end
  endtask

  task automatic test_coef_writes();
    clear_q();
    for (int k = 0; k < 9; k++) wcoef(k, int'($urandom_range(0, 30)) - 8);
    wcoef(9, 77);
    wcoef(15, -3);
    for (int n = 0; n < 25; n++) begin
      rand_taps();
      if (n == 18) wcoef(4, int'($urandom_range(40, 90)));
      if (n == 22) send(1'b1, 4, -20);
      else if (n == 23) send(1'b1, 12, 99);
      else send();
    end
    idle(6);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL coef count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].v != exp_q[i].v || obs_q[i].c != exp_q[i].c || obs_q[i].fd != exp_q[i].fd) begin
        bad++;
        $display("FAIL coef out[%0d]: got val=%0d cyc=%0d fd=%0b want val=%0d cyc=%0d fd=%0b",
                 i, obs_q[i].v, obs_q[i].c, obs_q[i].fd, exp_q[i].v, exp_q[i].c, exp_q[i].fd);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int k = 0; k < 9; k++) wcoef(k, int'($urandom_range(0, 60)) - 20);
    for (int n = 0; n < 50; n++) begin rand_taps(); send(); end
    idle(6);
    total++;
    if (obs_q.size() != 18) begin bad++; $display("FAIL b2b count: got %0d want 18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].v != exp_q[i].v || obs_q[i].c != exp_q[i].c || obs_q[i].fd != exp_q[i].fd) begin
        bad++;
        $display("FAIL b2b out[%0d]: got val=%0d cyc=%0d fd=%0b want val=%0d cyc=%0d fd=%0b",
                 i, obs_q[i].v, obs_q[i].c, obs_q[i].fd, exp_q[i].v, exp_q[i].c, exp_q[i].fd);
      end
    end
    total++;
    if (stray_fd != 0) begin bad++; $display("FAIL stray frame_done: got %0d want 0", stray_fd); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_box();
    test_sobel();
    test_gaps();
    test_reset_mid();
    test_coef_writes();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
